// File: rtl/tiny_cpu_pkg.sv
// Shared constants for the tiny 8-bit CPU: data-memory map, arbiter port
// indices and instruction opcodes used by the core and ROM.
package tiny_cpu_pkg;

  localparam int RAM_DEPTH = 30;
  localparam logic [4:0] ADDR_IO_IN  = 5'd30;
  localparam logic [4:0] ADDR_IO_OUT = 5'd31;

  localparam int PORT_C = 0;
  localparam int PORT_H = 1;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_OUT = 4'h7,
    OP_HLT = 4'hF
  } opcode_e;

endpackage

// File: rtl/tiny_cpu_rr_arb2.sv
// Two-way arbiter with a one-bit "last granted" pointer; grants are combinational
// from req and the pointer, which only moves when something is granted.
module tiny_cpu_rr_arb2
  import tiny_cpu_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[PORT_C] && req_i[PORT_H]) begin
      if ((FIXED_PRIO != 0) || (last_q == 1'(PORT_H))) begin
        gnt_o[PORT_C] = 1'b1;
      end else begin
        gnt_o[PORT_H] = 1'b1;
      end
    end else begin
      gnt_o = req_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[PORT_H]) begin
      last_d = 1'(PORT_H);
    end else if (gnt_o[PORT_C]) begin
      last_d = 1'(PORT_C);
    end
  end

  // Resetting to H lets C win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'(PORT_H);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tiny_cpu_mem_arbiter.sv
// Data-memory arbiter for the tiny CPU: 30-byte RAM, io_in window and io_out
// register, one access per cycle shared between core (C) and host loader (H).
module tiny_cpu_mem_arbiter
  import tiny_cpu_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c_req,
  input  logic       c_we,
  input  logic [4:0] c_addr,
  input  logic [7:0] c_wdata,
  input  logic       h_req,
  input  logic       h_we,
  input  logic [4:0] h_addr,
  input  logic [7:0] h_wdata,
  output logic       c_gnt,
  output logic       h_gnt,
  output logic       c_rvalid,
  output logic       h_rvalid,
  output logic [7:0] rdata,
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic [1:0] gnt;
  logic       sel_vld;
  logic       sel_we;
  logic [4:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       ram_hit;
  logic [7:0] rd_dat;

  logic [7:0] mem_q [0:RAM_DEPTH-1];
  logic [7:0] io_out_q, io_out_d;
  logic [7:0] rdata_q, rdata_d;
  logic       c_rvalid_q, c_rvalid_d;
  logic       h_rvalid_q, h_rvalid_d;

  tiny_cpu_rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req_i({h_req, c_req}),
    .gnt_o(gnt)
  );

  assign c_gnt = gnt[PORT_C];
  assign h_gnt = gnt[PORT_H];

  assign sel_vld   = c_gnt | h_gnt;
  assign sel_we    = h_gnt ? h_we    : c_we;
  assign sel_addr  = h_gnt ? h_addr  : c_addr;
  assign sel_wdata = h_gnt ? h_wdata : c_wdata;
  assign ram_hit   = (sel_addr < 5'(RAM_DEPTH));

  always_comb begin
    rd_dat = 8'h00;
    if (sel_addr == ADDR_IO_IN) begin
      rd_dat = io_in;
    end else if (sel_addr == ADDR_IO_OUT) begin
      rd_dat = io_out_q;
    end else if (ram_hit) begin
      rd_dat = mem_q[sel_addr];
    end
  end

  // Writes to the io_in window fall through every case and are dropped.
  always_comb begin
    io_out_d   = io_out_q;
    rdata_d    = rdata_q;
    c_rvalid_d = 1'b0;
    h_rvalid_d = 1'b0;
    if (sel_vld && sel_we && (sel_addr == ADDR_IO_OUT)) begin
      io_out_d = sel_wdata;
    end
    if (sel_vld && !sel_we) begin
      rdata_d    = rd_dat;
      c_rvalid_d = c_gnt;
      h_rvalid_d = h_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_q   <= 8'h00;
      rdata_q    <= 8'h00;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
    end else begin
      io_out_q   <= io_out_d;
      rdata_q    <= rdata_d;
      c_rvalid_q <= c_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
    end
  end

  // RAM has no reset so loaded contents survive a core reset.
  always_ff @(posedge clk) begin
    if (sel_vld && sel_we && ram_hit) begin
      mem_q[sel_addr] <= sel_wdata;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign h_rvalid = h_rvalid_q;
  assign rdata    = rdata_q;
  assign io_out   = io_out_q;

endmodule
